// File: rtl/sequential_divider_if.sv
// Handshake and operand/result bundle between a controller and the sequential divider.
// The controller drives start and operands; the divider returns status and results.
interface sequential_divider_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/sequential_divider.sv
// Unsigned restoring divider producing one quotient bit per clock,
// with a start/busy/done handshake for back-to-back issue.
module sequential_divider #(
  parameter int N = 4
) (
  input logic              clock,
  input logic              reset,
  sequential_divider_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;
  state_t state_next;

  // Partial remainder is kept N bits wide: it is always below the divisor.
  logic [N-1:0]  rem_r;
  logic [N-1:0]  q_r;
  logic [N-1:0]  d_r;
  logic [CW-1:0] count;

  logic [N-1:0]  quotient_r;
  logic [N-1:0]  remainder_r;
  logic          dbz_r;

  logic [N:0]    trial;
  logic          fits;
  logic [N-1:0]  rem_next;
  logic [N-1:0]  q_next;
  logic          last_iter;

  always_comb begin
    trial    = {rem_r, q_r[N-1]};
    fits     = (trial >= {1'b0, d_r});
    rem_next = fits ? (trial[N-1:0] - d_r) : trial[N-1:0];
    q_next   = {q_r[N-2:0], fits};
  end

  assign last_iter = (count == CW'(N - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result registers only move on a completed operation or on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_r       <= '0;
      q_r         <= '0;
      d_r         <= '0;
      count       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
            end else begin
              rem_r <= '0;
              q_r   <= bus.dividend;
              d_r   <= bus.divisor;
              count <= '0;
              dbz_r <= 1'b0;
            end
          end
        end
        RUN: begin
          rem_r <= rem_next;
          q_r   <= q_next;
          count <= count + CW'(1);
          if (last_iter) begin
            quotient_r  <= q_next;
            remainder_r <= rem_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_sequential_divider.sv
// Directed and table-driven checks of the sequential divider at N=4,
// plus an N=8 back-to-back stream against a reference model.
module tb_sequential_divider;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  sequential_divider_if #(.N(4)) bus4 ();
  sequential_divider_if #(.N(8)) bus8 ();

  sequential_divider #(.N(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4.slave)
  );

  sequential_divider #(.N(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8.slave)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_dbz;
    int         exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic check_output(input string name, input longint actual, input longint expected);
    total++;
    if (actual == expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b);
    bus4.start    = 1'b1;
    bus4.dividend = a;
    bus4.divisor  = b;
  endtask

  // Issue one N=4 operation from IDLE and check timing and results.
  task automatic run_op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er, input logic edbz,
                         input int elat);
    int lat;
    int busy_cycles;
    apply_stimulus(a, b);
    @(posedge clock); #1;
    bus4.start  = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    while (!bus4.done && lat < 20) begin
      if (bus4.busy) busy_cycles++;
      @(posedge clock); #1;
      lat++;
    end
    check_output({tag, " latency"}, lat, elat);
    check_output({tag, " busy cycles"}, busy_cycles, elat);
    check_output({tag, " busy at done"}, bus4.busy, 0);
    check_output({tag, " quotient"}, bus4.quotient, eq);
    check_output({tag, " remainder"}, bus4.remainder, er);
    check_output({tag, " div_by_zero"}, bus4.div_by_zero, edbz);
    @(posedge clock); #1;
    check_output({tag, " done one cycle"}, bus4.done, 0);
  endtask

  // Stream N=8 operations with start held high; done-to-done spacing shows throughput.
  task automatic stream8(input int n_ops);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eq;
    logic [7:0] er;
    logic       edbz;
    int         edges;
    int         esp;
    string      tag;
    bus8.start = 1'b1;
    for (int i = 0; i < n_ops; i++) begin
      if (i == 0) begin
        a = 8'd200; b = 8'd7;
      end else if (i == 1) begin
        a = 8'd255; b = 8'd0;
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      bus8.dividend = a;
      bus8.divisor  = b;
      if (b == 0) begin
        eq = 8'hFF; er = a; edbz = 1'b1;
      end else begin
        eq = a / b; er = a % b; edbz = 1'b0;
      end
      edges = 0;
      do begin
        @(posedge clock); #1;
        edges++;
      end while (!bus8.done && edges < 40);
      if (i == 0) esp = (b == 0) ? 1 : 9;
      else        esp = (b == 0) ? 2 : 10;
      tag = $sformatf("n8[%0d] %0d/%0d", i, a, b);
      check_output({tag, " spacing"}, edges, esp);
      check_output({tag, " quotient"}, bus8.quotient, eq);
      check_output({tag, " remainder"}, bus8.remainder, er);
      check_output({tag, " div_by_zero"}, bus8.div_by_zero, edbz);
      if (b != 0) begin
        check_output({tag, " invariant"},
                     ((longint'(bus8.quotient) * b + bus8.remainder == a) &&
                      (bus8.remainder < b)) ? 1 : 0, 1);
      end
    end
    bus8.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int dones;
    logic [3:0] got_q;
    logic [3:0] got_r;

    vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 4};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4};
    vecs[2] = '{4'd7,  4'd9,  4'd0,  4'd7, 1'b0, 4};
    vecs[3] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 4};
    vecs[4] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4};
    vecs[5] = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 0};
    vecs[6] = '{4'd6,  4'd4,  4'd1,  4'd2, 1'b0, 4};

    reset         = 1'b1;
    bus4.start    = 1'b0;
    bus4.dividend = '0;
    bus4.divisor  = '0;
    bus8.start    = 1'b0;
    bus8.dividend = '0;
    bus8.divisor  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    check_output("reset busy", bus4.busy, 0);
    check_output("reset done", bus4.done, 0);
    check_output("reset quotient", bus4.quotient, 0);
    check_output("reset remainder", bus4.remainder, 0);
    check_output("reset div_by_zero", bus4.div_by_zero, 0);
    check_output("reset n8 done", bus8.done, 0);

    for (int i = 0; i < 7; i++) begin
      run_op4($sformatf("vec%0d %0d/%0d", i, vecs[i].dividend, vecs[i].divisor),
              vecs[i].dividend, vecs[i].divisor, vecs[i].exp_q, vecs[i].exp_r,
              vecs[i].exp_dbz, vecs[i].exp_lat);
    end

    // Start pulsed with other operands during RUN must be ignored.
    apply_stimulus(4'd14, 4'd4);
    @(posedge clock); #1;
    bus4.start = 1'b0;
    @(posedge clock); #1;
    apply_stimulus(4'd3, 4'd1);
    @(posedge clock); #1;
    check_output("ignore start busy", bus4.busy, 1);
    @(posedge clock); #1;
    bus4.start = 1'b0;
    dones = 0;
    got_q = '0;
    got_r = '0;
    for (int c = 0; c < 10; c++) begin
      if (bus4.done) begin
        dones++;
        got_q = bus4.quotient;
        got_r = bus4.remainder;
      end
      @(posedge clock); #1;
    end
    check_output("ignore start done count", dones, 1);
    check_output("ignore start quotient", got_q, 3);
    check_output("ignore start remainder", got_r, 2);

    // Reset in the middle of RUN aborts without a done pulse.
    apply_stimulus(4'd11, 4'd2);
    @(posedge clock); #1;
    bus4.start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_output("abort busy", bus4.busy, 0);
    check_output("abort quotient", bus4.quotient, 0);
    check_output("abort remainder", bus4.remainder, 0);
    check_output("abort div_by_zero", bus4.div_by_zero, 0);
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus4.done) dones++;
      @(posedge clock); #1;
    end
    check_output("abort done count", dones, 0);
    run_op4("after abort 11/2", 4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 4);

    stream8(1002);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
